// File: rtl/sram_bus_pkg.sv
// sram_bus_pkg: shared widths, size codes and response-queue entry type for the SRAM-like bus
package sram_bus_pkg;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = DATA_W / 8;
    localparam int TIMER_W = 8;
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    typedef struct packed {
        logic               wr;
        logic [DATA_W-1:0]  data;
        logic [TIMER_W-1:0] timer;
    } entry_t;
endpackage

// File: rtl/sram_resp_queue.sv
// sram_resp_queue: circular response buffer whose entries count their own latency down
module sram_resp_queue import sram_bus_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 push_entry,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output logic                   head_valid,
    output entry_t                 head
);
    localparam int PW = $clog2(DEPTH);
    entry_t ent_q [DEPTH];
    entry_t ent_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0] hd_q, hd_d, tl_q, tl_d;
    logic [PW:0] cnt_q, cnt_d;
    always_comb begin
        ent_d = ent_q;
        vld_d = vld_q;
        for (int i = 0; i < DEPTH; i++)
            if (vld_q[i] && ent_q[i].timer != '0) ent_d[i].timer = ent_q[i].timer - 1'b1;
        if (pop) vld_d[hd_q] = 1'b0;
        if (push) begin
            ent_d[tl_q] = push_entry;
            vld_d[tl_q] = 1'b1;
        end
        hd_d = pop ? hd_q + 1'b1 : hd_q;
        tl_d = push ? tl_q + 1'b1 : tl_q;
        cnt_d = (push && !pop) ? cnt_q + 1'b1 : (pop && !push) ? cnt_q - 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            hd_q  <= '0;
            tl_q  <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            hd_q  <= hd_d;
            tl_q  <= tl_d;
            cnt_q <= cnt_d;
        end
        ent_q <= ent_d;
    end
    assign count      = cnt_q;
    assign head_valid = vld_q[hd_q];
    assign head       = ent_q[hd_q];
endmodule

// File: rtl/sram_like_slave.sv
// sram_like_slave: SRAM-like bus responder with in-order delayed responses.
// Defining SRAM_RAND_DELAY_EN adds LFSR-driven accept stalls and response delays.
module sram_like_slave import sram_bus_pkg::*; #(
    parameter int MEM_AW = 12,
    parameter int DEPTH  = 4,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [DATA_W-1:0] rdata
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [DATA_W-1:0] mem [2**MEM_AW];
    logic [MEM_AW-1:0] idx;
    logic [CW-1:0] count;
    logic head_valid, hs, gate;
    logic [TIMER_W-1:0] extra;
    entry_t head, push_entry;
    logic unused_ok;
`ifdef SRAM_RAND_DELAY_EN
    logic [7:0] lfsr_q, lfsr_d;
    always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    always_ff @(posedge clk) lfsr_q <= reset ? 8'h5A : lfsr_d;
    assign gate  = lfsr_q[0];
    assign extra = TIMER_W'(lfsr_q[2:1]);
`else
    assign gate  = 1'b1;
    assign extra = '0;
`endif
    assign idx       = addr[MEM_AW+1:2];
    assign unused_ok = ^{size, addr[ADDR_W-1:MEM_AW+2], addr[1:0]};
    // a full queue blocks accepts even while its head pops this cycle
    assign addr_ok   = req & ~reset & gate & (count < CW'(DEPTH));
    assign hs        = req & addr_ok;
    assign data_ok   = head_valid & (head.timer == '0) & ~reset;
    assign rdata     = (data_ok & ~head.wr) ? head.data : '0;
    always_comb begin
        push_entry.wr    = wr;
        push_entry.data  = mem[idx];
        push_entry.timer = TIMER_W'(LAT - 1) + extra;
    end
    always_ff @(posedge clk)
        if (hs && wr)
            for (int b = 0; b < STRB_W; b++)
                if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    sram_resp_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (hs),
        .push_entry (push_entry),
        .pop        (data_ok),
        .count      (count),
        .head_valid (head_valid),
        .head       (head)
    );
endmodule

// File: tb/tb_sram_like_slave.sv
// tb_sram_like_slave: directed checks of a LAT=2 slave and a LAT=6 slave sharing one stimulus stream
module tb_sram_like_slave;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req = 1'b0, wr = 1'b0;
    logic [1:0] size = 2'd2;
    logic [3:0] wstrb = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic ao_a, dok_a, ao_b, dok_b;
    logic [31:0] rd_a, rd_b;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    sram_like_slave #(.MEM_AW(12), .DEPTH(4), .LAT(2)) dut_a (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(ao_a), .data_ok(dok_a), .rdata(rd_a)
    );
    sram_like_slave #(.MEM_AW(12), .DEPTH(4), .LAT(6)) dut_b (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(ao_b), .data_ok(dok_b), .rdata(rd_b)
    );
    task automatic drive(input logic rs, input logic r, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        reset = rs; req = r; wr = w; wstrb = s; addr = a; wdata = d;
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic exp_a(input string tag, input logic ao, input logic dok, input logic [31:0] rd);
        chk({tag, "_a_addr_ok"}, 32'(ao_a), 32'(ao));
        chk({tag, "_a_data_ok"}, 32'(dok_a), 32'(dok));
        chk({tag, "_a_rdata"}, rd_a, rd);
    endtask
    task automatic exp_b(input string tag, input logic ao, input logic dok, input logic [31:0] rd);
        chk({tag, "_b_addr_ok"}, 32'(ao_b), 32'(ao));
        chk({tag, "_b_data_ok"}, 32'(dok_b), 32'(dok));
        chk({tag, "_b_rdata"}, rd_b, rd);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask
    initial begin
        drive(1, 1, 0, 0, 32'h40, 0);
        exp_a("reset", 0, 0, 0);
        exp_b("reset", 0, 0, 0);
        // preload word 0x10 with a full-width write
        drive(0, 1, 1, 4'hF, 32'h40, 32'hDEADBEEF);
        exp_a("prewr", 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        exp_a("prewr_wait", 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        exp_a("prewr_resp", 0, 1, 0);
        drive(0, 1, 0, 0, 32'h40, 0);
        exp_a("rd_accept", 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        exp_a("rd_wait", 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        exp_a("rd_resp", 0, 1, 32'hDEADBEEF);
        drive(0, 0, 0, 0, 0, 0);
        exp_a("rd_once", 0, 0, 0);
        drive(0, 1, 1, 4'b0011, 32'h40, 32'h12345678);
        exp_a("wr_lo", 1, 0, 0);
        drive(0, 1, 0, 4'hF, 32'h40, 32'hFFFFFFFF);
        exp_a("rd_after_wr", 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        exp_a("wr_lo_resp", 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        exp_a("merge_resp", 0, 1, 32'hDEAD5678);
        drive(0, 0, 0, 0, 0, 0);
        exp_a("merge_done", 0, 0, 0);
        idle(6);
        // 4 writes, 4 reads, one aliased read, then drain
        for (int s = 0; s < 11; s++) begin
            if (s < 4) drive(0, 1, 1, 4'hF, 32'(4 * s), 32'h10000000 + 32'(s));
            else if (s < 8) drive(0, 1, 0, 0, 32'(4 * (s - 4)), 0);
            else if (s == 8) drive(0, 1, 0, 0, 32'h4040, 0);
            else drive(0, 0, 0, 0, 0, 0);
            exp_a("stream", s < 9, s >= 2,
                  s < 6 ? 32'h0 : s < 10 ? 32'h10000000 + 32'(s - 6) : 32'hDEAD5678);
        end
        idle(8);
        // LAT=6 slave fills its 4 slots and stalls the held request
        for (int g = 0; g < 15; g++) begin
            if (g < 4) drive(0, 1, 0, 0, 32'(4 * g), 0);
            else if (g < 8) drive(0, 1, 0, 0, 32'h0, 0);
            else if (g == 8) drive(0, 1, 0, 0, 32'h4, 0);
            else drive(0, 0, 0, 0, 0, 0);
            exp_b("stall", g < 4 || g == 7 || g == 8, (g >= 6 && g <= 9) || g >= 13,
                  (g >= 6 && g <= 9) ? 32'h10000000 + 32'(g - 6) :
                  g == 13 ? 32'h10000000 : g == 14 ? 32'h10000001 : 32'h0);
        end
        idle(8);
        for (int h = 0; h < 3; h++) begin
            drive(0, 1, 0, 0, 32'(4 * h), 0);
            exp_a("mid", 1, h == 2, h == 2 ? 32'h10000000 : 32'h0);
            exp_b("mid", 1, 0, 0);
        end
        drive(1, 1, 0, 0, 32'hC, 0);
        exp_a("mid_reset", 0, 0, 0);
        exp_b("mid_reset", 0, 0, 0);
        for (int h = 0; h < 7; h++) begin
            drive(0, 0, 0, 0, 0, 0);
            exp_a("flushed", 0, 0, 0);
            exp_b("flushed", 0, 0, 0);
        end
        drive(0, 1, 0, 0, 32'hC, 0);
        exp_a("post_rd", 1, 0, 0);
        exp_b("post_rd", 1, 0, 0);
        for (int k = 1; k < 8; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            exp_a("post_resp", 0, k == 2, k == 2 ? 32'h10000003 : 32'h0);
            exp_b("post_resp", 0, k == 6, k == 6 ? 32'h10000003 : 32'h0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
